// File: rtl/nasti_credit_arbiter.sv
// Round-robin address-channel arbiter with per-port outstanding-transaction
// credits. A sticky one-hot grant is held until the master side accepts the
// address beat. Ports whose in-flight count has reached MAX_OUT are skipped
// until a completion frees a slot.
module nasti_credit_arbiter #(
  parameter int N       = 8,
  parameter int MAX_OUT = 4,
  parameter int CW      = $clog2(MAX_OUT + 1),
  parameter int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic          enable,
  input  logic          ack,
  input  logic          done_valid,
  input  logic [IW-1:0] done_port,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  output logic [N-1:0]  busy,
  output logic          idle,
  output logic          err
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  gnt_reg, gnt_next;
  logic [IW-1:0] gnt_idx_reg, gnt_idx_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic          err_reg;

  logic [N-1:0]  elig;
  logic [N-1:0]  cnt_zero;
  logic [N-1:0]  underflow;
  logic          bad_port;
  logic [IW:0]   pick_idle;
  logic [IW:0]   pick_ack;
  logic [IW-1:0] ptr_adv;

  // Returns {found, index} of the first set bit of v scanning p, p+1, ...
  // modulo N. Scanning backwards lets the smallest offset overwrite last.
  function automatic logic [IW:0] pick(input logic [N-1:0] v, input logic [IW-1:0] p);
    logic [IW:0] res;
    logic [IW:0] j;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, p} + (IW+1)'(k);
      if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
      if (v[j[IW-1:0]]) res = {1'b1, j[IW-1:0]};
    end
    return res;
  endfunction

  // Pointer position just after the currently granted port, wrapping at N.
  always_comb begin
    logic [IW:0] nx;
    nx = {1'b0, gnt_idx_reg} + (IW+1)'(1);
    if (nx >= (IW+1)'(N)) nx = '0;
    ptr_adv = nx[IW-1:0];
  end

  assign elig      = req & ~busy;
  assign pick_idle = pick(elig, ptr_reg);
  // The port whose beat is being accepted is excluded from the same-cycle re-arbitration.
  assign pick_ack  = pick(elig & ~gnt_reg, ptr_adv);

  // Per-port in-flight counters; an accept and a completion on the same port cancel.
  for (genvar gi = 0; gi < N; gi++) begin : g_port
    logic [CW-1:0] cnt_reg;
    logic          inc;
    logic          dec;

    assign inc           = (state_reg == GRANT) && ack && (gnt_idx_reg == IW'(gi));
    assign dec           = done_valid && (done_port == IW'(gi));
    assign underflow[gi] = dec && (cnt_reg == '0);
    assign busy[gi]      = (cnt_reg == CW'(MAX_OUT));
    assign cnt_zero[gi]  = (cnt_reg == '0);

    // Counter update: saturates at zero on a spurious completion.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt_reg <= '0;
      end else if (inc && !dec) begin
        cnt_reg <= cnt_reg + CW'(1);
      end else if (dec && !inc && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - CW'(1);
      end
    end
  end

  assign bad_port = ({1'b0, done_port} >= (IW+1)'(N));

  // Grant state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      gnt_idx_reg <= '0;
      ptr_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      gnt_idx_reg <= gnt_idx_next;
      ptr_reg     <= ptr_next;
    end
  end

  // Next grant: issue from IDLE, hold while requested, re-arbitrate on accept.
  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    gnt_idx_next = gnt_idx_reg;
    ptr_next     = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (enable && pick_idle[IW]) begin
          state_next   = GRANT;
          gnt_idx_next = pick_idle[IW-1:0];
          gnt_next     = N'(1) << pick_idle[IW-1:0];
        end
      end
      GRANT: begin
        if (ack) begin
          ptr_next = ptr_adv;
          if (enable && pick_ack[IW]) begin
            gnt_idx_next = pick_ack[IW-1:0];
            gnt_next     = N'(1) << pick_ack[IW-1:0];
          end else begin
            state_next   = IDLE;
            gnt_idx_next = '0;
            gnt_next     = '0;
          end
        end else if (!req[gnt_idx_reg]) begin
          // Requester withdrew before acceptance: drop the grant, no credit taken.
          state_next   = IDLE;
          gnt_idx_next = '0;
          gnt_next     = '0;
        end
      end
      default: begin
        state_next   = IDLE;
        gnt_idx_next = '0;
        gnt_next     = '0;
      end
    endcase
  end

  // Sticky error on a completion for an empty counter or a nonexistent port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_reg <= 1'b0;
    end else if (done_valid && (bad_port || (|underflow))) begin
      err_reg <= 1'b1;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = (state_reg == GRANT);
  assign gnt_idx   = gnt_idx_reg;
  assign idle      = (&cnt_zero) && (state_reg != GRANT);
  assign err       = err_reg;

endmodule

// File: tb/tb_nasti_credit_arbiter.sv
// Directed and randomized checks of nasti_credit_arbiter against a
// transaction-level reference model kept in the bench.
module tb_nasti_credit_arbiter;

  localparam int N    = 8;
  localparam int MAXO = 2;
  localparam int IW   = 3;

  logic          clk;
  logic          rstn;
  logic [N-1:0]  req;
  logic          enable;
  logic          ack;
  logic          done_valid;
  logic [IW-1:0] done_port;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;
  logic [N-1:0]  busy;
  logic          idle;
  logic          err;

  nasti_credit_arbiter #(.N(N), .MAX_OUT(MAXO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .enable     (enable),
    .ack        (ack),
    .done_valid (done_valid),
    .done_port  (done_port),
    .gnt        (gnt),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .busy       (busy),
    .idle       (idle),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: grant held or not, which port, rotation pointer, credits.
  bit m_hold;
  int m_idx;
  int m_ptr;
  int m_cnt [N];
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hold = 0;
    m_idx  = 0;
    m_ptr  = 0;
    m_err  = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_update();
    logic [N-1:0] e;
    bit accepted;
    int w;
    for (int i = 0; i < N; i++) e[i] = req[i] && (m_cnt[i] < MAXO);
    accepted = m_hold && ack;
    for (int i = 0; i < N; i++) begin
      bit inc, dec;
      inc = accepted && (m_idx == i);
      dec = done_valid && (int'(done_port) == i);
      if (dec && m_cnt[i] == 0) m_err = 1;
      if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
    end
    if (accepted)
      $display("txn: port %0d address accepted, outstanding now %0d", m_idx, m_cnt[m_idx]);
    if (!m_hold) begin
      w = pick(e, m_ptr);
      if (enable && w >= 0) begin
        m_hold = 1;
        m_idx  = w;
      end
    end else if (ack) begin
      m_ptr = (m_idx + 1) % N;
      e[m_idx] = 1'b0;
      w = pick(e, m_ptr);
      if (enable && w >= 0) m_idx = w;
      else m_hold = 0;
    end else if (!req[m_idx]) begin
      m_hold = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg;
    logic [N-1:0] eb;
    bit ei;
    eg = '0;
    if (m_hold) eg[m_idx] = 1'b1;
    ei = !m_hold;
    for (int i = 0; i < N; i++) begin
      eb[i] = (m_cnt[i] == MAXO);
      if (m_cnt[i] != 0) ei = 0;
    end
    check({tag, ".gnt"},       32'(gnt),       32'(eg));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_hold));
    check({tag, ".gnt_idx"},   32'(gnt_idx),   m_hold ? 32'(m_idx) : 32'd0);
    check({tag, ".busy"},      32'(busy),      32'(eb));
    check({tag, ".idle"},      32'(idle),      32'(ei));
    check({tag, ".err"},       32'(err),       32'(m_err));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic [N-1:0] r, input logic en, input logic a,
                        input logic dv, input logic [IW-1:0] dp);
    req = r; enable = en; ack = a; done_valid = dv; done_port = dp;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    rstn = 1'b0;
    set_in('0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b1;
    set_in('0, 1'b0, 1'b0, 1'b0, '0);
    #2;
    do_reset("reset");

    // Single request, then accept.
    set_in(8'h01, 1'b1, 1'b0, 1'b0, '0);
    step("single_grant");
    check("single_gnt_01", 32'(gnt), 32'h01);
    set_in(8'h00, 1'b1, 1'b1, 1'b0, '0);
    step("single_ack");
    check("single_not_idle", 32'(idle), 32'd0);
    set_in(8'h00, 1'b1, 1'b0, 1'b0, '0);
    step("single_after");

    // All ports requesting with ack every cycle: rotating grants until credits run out.
    do_reset("reset_rr");
    set_in(8'hFF, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 18; i++) step($sformatf("rr_%0d", i));
    check("rr_all_busy", 32'(busy), 32'hFF);

    // Credit limit on port 2, released by a completion.
    do_reset("reset_credit");
    set_in(8'h04, 1'b1, 1'b0, 1'b0, '0); step("cr_g1");
    set_in(8'h04, 1'b1, 1'b1, 1'b0, '0); step("cr_a1");
    set_in(8'h04, 1'b1, 1'b0, 1'b0, '0); step("cr_g2");
    set_in(8'h04, 1'b1, 1'b1, 1'b0, '0); step("cr_a2");
    set_in(8'h04, 1'b1, 1'b0, 1'b0, '0); step("cr_blocked");
    check("cr_busy2", 32'(busy[2]), 32'd1);
    set_in(8'h04, 1'b1, 1'b0, 1'b1, 3'd2); step("cr_done");
    set_in(8'h04, 1'b1, 1'b0, 1'b0, '0); step("cr_regrant");
    check("cr_gnt_04", 32'(gnt), 32'h04);

    // Sticky grant on port 3 despite enable drop and a new request.
    do_reset("reset_hold");
    set_in(8'h08, 1'b1, 1'b0, 1'b0, '0); step("hold_g");
    set_in(8'h28, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step($sformatf("hold_%0d", i));
    check("hold_gnt_08", 32'(gnt), 32'h08);
    set_in(8'h28, 1'b0, 1'b1, 1'b0, '0); step("hold_ack");
    set_in(8'h28, 1'b0, 1'b0, 1'b0, '0); step("hold_disabled");

    // Same-cycle accept and completion on port 1, then spurious completion on port 6.
    do_reset("reset_same");
    set_in(8'h02, 1'b1, 1'b0, 1'b0, '0); step("same_g1");
    set_in(8'h02, 1'b1, 1'b1, 1'b0, '0); step("same_a1");
    set_in(8'h02, 1'b1, 1'b0, 1'b0, '0); step("same_g2");
    set_in(8'h00, 1'b1, 1'b1, 1'b1, 3'd1); step("same_ack_done");
    check("same_not_busy1", 32'(busy[1]), 32'd0);
    set_in(8'h00, 1'b1, 1'b0, 1'b1, 3'd1); step("same_drain");
    check("same_idle", 32'(idle), 32'd1);
    set_in(8'h00, 1'b1, 1'b0, 1'b1, 3'd6); step("err_port6");
    check("err_set", 32'(err), 32'd1);
    set_in(8'h00, 1'b1, 1'b0, 1'b0, '0); step("err_sticky");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      set_in(8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0), 3'($urandom_range(0, N - 1)));
      step($sformatf("rand_%0d", i));
    end

    // Reset in the middle of a held grant with credits outstanding.
    set_in(8'hFF, 1'b1, 1'b1, 1'b0, '0);
    step("pre_rst_a");
    set_in(8'hFF, 1'b1, 1'b0, 1'b0, '0);
    step("pre_rst_b");
    #2;
    do_reset("mid_reset");
    set_in(8'hFF, 1'b1, 1'b0, 1'b0, '0);
    step("post_reset");
    check("post_reset_gnt_01", 32'(gnt), 32'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
